divider_param: RTL
==================

Name: divider_param

Overview:
- Parametrised iterative restoring divider; next generation of the team's fixed 10-bit divider.
- Adds generic width, optional fractional quotient bits (fixed-point), signed/unsigned mode per operation, and a remainder output.
- Keeps the start/busy/valid handshake and dvz/ovf flags, so it drops into existing controllers as an arithmetic unit.

Parameters:
WIDTH, 10, operand, quotient and remainder width in bits (>=2)
FRAC, 0, fractional quotient bits; dividend is scaled by 2^FRAC before dividing (0..WIDTH)
SAT, 1, 1 = saturate quotient on overflow; 0 = q_out is low WIDTH bits of the raw quotient

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
sclr  input  1  synchronous clear / abort, active-high
start  input  1  request; sampled only while busy=0
signed_mode  input  1  1 = two's-complement operands; sampled with start
a_in  input  WIDTH  dividend
b_in  input  WIDTH  divisor
q_out  output  WIDTH  quotient; Q(WIDTH-FRAC).FRAC format
r_out  output  WIDTH  remainder of (a<<FRAC)/b
busy  output  1  operation in progress
valid  output  1  one-cycle pulse: results and flags are updated
dvz  output  1  divide by zero for the last operation
ovf  output  1  quotient overflow for the last operation

Behaviour:
- Reset (rst_n=0, async) and sclr=1 (sync, highest priority after reset) produce the same state:
  - state IDLE
  - q_out=0, r_out=0, busy=0, valid=0, dvz=0, ovf=0
  - internal counter and registers cleared
- sclr mid-operation aborts the operation; no valid pulse is produced.
- ITER = WIDTH+FRAC. Iteration counter width is $clog2(ITER+1).
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and b_in!=0: latch operands and signed_mode.
    - Magnitudes: |a| zero-extended and shifted left by FRAC; |b| held in WIDTH+1 bits.
    - Latch the result sign (a_sign^b_sign) and the remainder sign (a_sign); both are 0 when unsigned.
    - Go to CALC with busy=1 from the next cycle.
  - start=1 and b_in==0: go to DONE.
    - q_out=0, r_out=0, dvz=1, ovf=0.
    - busy stays 0.
- CALC (ITER cycles):
  - Each cycle, shift {ACC,Q} left by 1.
  - Trial-subtract |b| from ACC. If the result is non-negative, keep it and set Q lsb=1; otherwise restore and set Q lsb=0.
  - Counter increments; after iteration ITER go to FIX.
- FIX (1 cycle):
  - Apply signs: quotient negated if the result sign is set; remainder takes the dividend's sign (truncating division).
  - Overflow limits on the magnitude Qm:
    - unsigned: Qm > 2^WIDTH-1
    - signed positive: Qm > 2^(WIDTH-1)-1
    - signed negative: Qm > 2^(WIDTH-1)
  - On overflow: ovf=1, and q_out saturates (SAT=1) to the max/min of the format, or wraps (SAT=0).
  - r_out is always the exact remainder.
  - dvz=0.
  - Register all outputs; go to DONE.
- DONE (1 cycle): valid=1, busy=0; return to IDLE.
- Latency: start sampled at edge k gives valid=1 during the cycle after edge k+ITER+2. The dvz case gives valid after edge k+1.
- busy=1 in CALC and FIX only. start while busy, or in the DONE cycle, is ignored (no queueing).
- q_out, r_out, dvz and ovf hold their values until the next FIX/dvz update or a clear. They are not cleared at the next start.
- Operands are sampled once; a_in and b_in may change during busy without effect.

Decomposition:
- Package divider_pkg holds:
  - state enum (IDLE, CALC, FIX, DONE)
  - function for the overflow limit given WIDTH and signed flag
  - localparam helpers for ITER and the counter width
- One natural sub-module, divider_step: combinational shift/trial-subtract/restore for one iteration, parametrised on WIDTH+FRAC. The FSM, counter and sign fix-up stay in the top.

Test Plan:
- WIDTH=10, FRAC=0, unsigned, 100/7 -> after 12 cycles valid=1: q_out=14, r_out=2, ovf=0, dvz=0; busy high for exactly 11 cycles.
- Signed mode, -100/7 (a_in=0x39C):
  - q_out=0x3F2 (-14), r_out=0x3FE (-2).
  - Repeat with -512/-1: ovf=1, q_out=0x1FF (SAT=1) or 0x200 (SAT=0).
- FRAC=4, unsigned:
  - 3/2 -> q_out=24 (1.5), r_out=0.
  - 1000/1 -> ovf=1, q_out=1023.
- b_in=0 with start -> valid next cycle, dvz=1, q_out=0, busy never asserted; next 9/3 -> dvz=0, q_out=3.
- Start pulsed again while busy, and a_in/b_in changed mid-operation -> result matches the originally sampled operands; exactly one valid pulse.
- Abort and reset:
  - sclr asserted in CALC cycle 5 -> next cycle busy=0, all outputs 0, no valid.
  - rst_n pulsed low asynchronously mid-FIX -> outputs 0 immediately; a fresh start then completes normally.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the parametrised restoring divider.
// Overflow limits are returned at a fixed wide width so callers can compare magnitudes directly.
package divider_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam int LIM_W = 128;

   function automatic int iter_of(input int width, input int frac);
      return width + frac;
   endfunction

   function automatic int cnt_w(input int width, input int frac);
      return $clog2(width + frac + 1);
   endfunction

   // Largest quotient magnitude representable for the operation's sign combination.
   function automatic logic [LIM_W-1:0] ovf_limit(input int width, input logic sgn, input logic neg);
      logic [LIM_W-1:0] one;
      one = LIM_W'(1);
      if (!sgn)
         return (one << width) - one;
      else if (neg)
         return one << (width - 1);
      else
         return (one << (width - 1)) - one;
   endfunction

endpackage

// File: rtl/divider_if.sv
// Operand/result bundle between a controller (master) and the divider (slave).
interface divider_if #(parameter int WIDTH = 10);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] q_out;
   logic [WIDTH-1:0] r_out;
   logic             busy;
   logic             valid;
   logic             dvz;
   logic             ovf;

   modport master (output start, signed_mode, a_in, b_in,
                   input  q_out, r_out, busy, valid, dvz, ovf);
   modport slave  (input  start, signed_mode, a_in, b_in,
                   output q_out, r_out, busy, valid, dvz, ovf);
endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {acc,q} left, trial-subtract divisor, restore on borrow.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module divider_step #(
   parameter int DW = 10,
   parameter int QW = 10
) (
   input  logic [DW:0]   acc_i,
   input  logic [QW-1:0] q_i,
   input  logic [DW:0]   d_i,
   output logic [DW:0]   acc_o,
   output logic [QW-1:0] q_o
);

   logic [DW+1:0] shifted;
   logic [DW+1:0] trial;

   always_comb begin
      shifted = {acc_i, q_i[QW-1]};
      trial   = shifted - {1'b0, d_i};
      // acc stays below the divisor, so the top bit of trial is a clean borrow flag.
      if (trial[DW+1]) begin
         acc_o = shifted[DW:0];
         q_o   = {q_i[QW-2:0], 1'b0};
      end else begin
         acc_o = trial[DW:0];
         q_o   = {q_i[QW-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/divider_param.sv
// Iterative signed/unsigned fixed-point restoring divider with remainder, dvz and ovf flags.
// Latency: valid pulses WIDTH+FRAC+2 cycles after start is sampled (1 cycle for divide-by-zero).
// Backpressure: start is ignored while busy or finishing; no queueing, results hold until next update.
module divider_param
   import divider_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int FRAC  = 0,
   parameter int SAT   = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     sclr,
   divider_if.slave dif
);

   localparam int ITER = iter_of(WIDTH, FRAC);
   localparam int CW   = cnt_w(WIDTH, FRAC);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [ITER-1:0]  qm_q, qm_d;
   logic [WIDTH:0]   dm_q, dm_d;
   logic             qsign_q, qsign_d;
   logic             rsign_q, rsign_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH-1:0] q_out_q, q_out_d;
   logic [WIDTH-1:0] r_out_q, r_out_d;
   logic             dvz_q, dvz_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   step_acc;
   logic [ITER-1:0]  step_q;
   logic [WIDTH-1:0] qm_low, q_wrap, r_mag, r_fix, sat_val;
   logic             ovf_now;

   divider_step #(.DW(WIDTH), .QW(ITER)) u_step (
      .acc_i (acc_q),
      .q_i   (qm_q),
      .d_i   (dm_q),
      .acc_o (step_acc),
      .q_o   (step_q)
   );

   always_comb begin
      a_neg   = dif.signed_mode & dif.a_in[WIDTH-1];
      b_neg   = dif.signed_mode & dif.b_in[WIDTH-1];
      a_mag   = a_neg ? -dif.a_in : dif.a_in;
      b_mag   = b_neg ? -dif.b_in : dif.b_in;
      qm_low  = qm_q[WIDTH-1:0];
      q_wrap  = qsign_q ? -qm_low : qm_low;
      r_mag   = acc_q[WIDTH-1:0];
      r_fix   = rsign_q ? -r_mag : r_mag;
      ovf_now = LIM_W'(qm_q) > ovf_limit(WIDTH, sgn_q, qsign_q);
      if (!sgn_q)
         sat_val = '1;
      else if (qsign_q)
         sat_val = {1'b1, {(WIDTH-1){1'b0}}};
      else
         sat_val = {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      qm_d    = qm_q;
      dm_d    = dm_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      sgn_d   = sgn_q;
      q_out_d = q_out_q;
      r_out_d = r_out_q;
      dvz_d   = dvz_q;
      ovf_d   = ovf_q;
      valid_d = (state_q == DONE);
      case (state_q)
         IDLE: begin
            if (dif.start) begin
               if (dif.b_in == '0) begin
                  state_d = DONE;
                  q_out_d = '0;
                  r_out_d = '0;
                  dvz_d   = 1'b1;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = CALC;
                  cnt_d   = '0;
                  acc_d   = '0;
                  qm_d    = ITER'(a_mag) << FRAC;
                  dm_d    = {1'b0, b_mag};
                  qsign_d = a_neg ^ b_neg;
                  rsign_d = a_neg;
                  sgn_d   = dif.signed_mode;
               end
            end
         end
         CALC: begin
            acc_d = step_acc;
            qm_d  = step_q;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1))
               state_d = FIX;
         end
         FIX: begin
            q_out_d = (ovf_now && (SAT != 0)) ? sat_val : q_wrap;
            r_out_d = r_fix;
            dvz_d   = 1'b0;
            ovf_d   = ovf_now;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Synchronous clear lands in exactly the reset state, including aborting any valid.
      if (sclr) begin
         state_d = IDLE;
         cnt_d   = '0;
         acc_d   = '0;
         qm_d    = '0;
         dm_d    = '0;
         qsign_d = 1'b0;
         rsign_d = 1'b0;
         sgn_d   = 1'b0;
         q_out_d = '0;
         r_out_d = '0;
         dvz_d   = 1'b0;
         ovf_d   = 1'b0;
         valid_d = 1'b0;
      end
      busy_d = (state_d == CALC) || (state_d == FIX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         qm_q    <= '0;
         dm_q    <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         sgn_q   <= 1'b0;
         q_out_q <= '0;
         r_out_q <= '0;
         dvz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         qm_q    <= qm_d;
         dm_q    <= dm_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         sgn_q   <= sgn_d;
         q_out_q <= q_out_d;
         r_out_q <= r_out_d;
         dvz_q   <= dvz_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign dif.q_out = q_out_q;
   assign dif.r_out = r_out_q;
   assign dif.busy  = busy_q;
   assign dif.valid = valid_q;
   assign dif.dvz   = dvz_q;
   assign dif.ovf   = ovf_q;

endmodule
